dp_ram_clr: RTL and testbench

- Parametrised simple dual-port RAM: one write port, one read port, single clock. Successor to the single-port 1024x4 inferred RAM.
- Adds independent read/write addresses, a read-valid pipeline, selectable read-during-write behaviour, an optional output register stage and an optional clear-on-reset sweep.
- Used as the VGA frame/tile buffer: the pixel pipeline reads while the pattern/update logic writes. Must infer iCE40 SB_RAM40_4K (no reset on the memory array itself).

---
 rtl/dp_ram_clr.sv | 117 +++++++++++
 tb/tb_dp_ram_clr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_clr.sv
// Simple dual-port RAM (one write port, one read port, one clock) with a read-valid
// pipeline, selectable read-during-write result, optional output register and clear sweep.
module dp_ram_clr #(
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DATA_WIDTH     = 4,
    parameter                        INIT_FILE      = "",
    parameter int                    OUT_REG        = 0,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    // No reset on the array so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  sweep_we;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  bypass;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        case (state)
            CLEAR: begin
                sweep_we = (CLEAR_ON_RESET != 0);
                cnt_nxt  = cnt + ADDR_WIDTH'(1);
                if (cnt == LAST_ADDR) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (CLEAR_ON_RESET != 0) && (state == CLEAR);
    assign wr_acc = wr_en && !busy;
    assign rd_acc = rd_en && !busy && !reset;
    assign bypass = (RDW_MODE != 0) && wr_acc && (wr_addr == rd_addr);

    // Sweep owns the write port; it only advances on edges where reset is low.
    always_ff @(posedge clk) begin
        if (sweep_we && !reset) begin
            mem[cnt] <= CLEAR_VALUE;
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage p0: array read (pre-write word unless bypassed)
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) data_p0 <= bypass ? wr_data : mem[rd_addr];
        end
    end

    // Stage p1: optional output register
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  vld_p1;
            logic [DATA_WIDTH-1:0] data_p1;

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) data_p1 <= data_p0;
                end
            end

            assign rd_data  = data_p1;
            assign rd_valid = vld_p1;
        end else begin : g_no_out_reg
            assign rd_data  = data_p0;
            assign rd_valid = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_clr.sv
// Scoreboard bench for dp_ram_clr: three instances (1-cycle/old-data, 2-cycle/bypass,
// 16-word clear-sweep) driven with directed and random traffic against an array model.
`timescale 1ns/1ps
module tb_dp_ram_clr;

    typedef struct {
        logic [3:0] d;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_ab;
    logic       rst_c;
    logic       we  [3];
    logic       re  [3];
    logic [9:0] wa  [3];
    logic [9:0] ra  [3];
    logic [3:0] wd  [3];
    logic [3:0] rdd [3];
    logic       rdv [3];
    logic       bsy [3];

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         sweep_left  = 0;
    bit         exp_busy    = 1'b1;
    int         lat [3];
    bit         rdw [3];
    logic [3:0] last [3];
    logic [3:0] mdl [3][1024];
    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       q2[$];

    dp_ram_clr #(.ADDR_WIDTH(10), .DATA_WIDTH(4), .OUT_REG(0), .RDW_MODE(0),
                 .CLEAR_ON_RESET(0)) u_a (
        .clk(clk), .reset(rst_ab), .wr_en(we[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
        .rd_en(re[0]), .rd_addr(ra[0]), .rd_data(rdd[0]), .rd_valid(rdv[0]), .busy(bsy[0]));

    dp_ram_clr #(.ADDR_WIDTH(10), .DATA_WIDTH(4), .OUT_REG(1), .RDW_MODE(1),
                 .CLEAR_ON_RESET(0)) u_b (
        .clk(clk), .reset(rst_ab), .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
        .rd_en(re[1]), .rd_addr(ra[1]), .rd_data(rdd[1]), .rd_valid(rdv[1]), .busy(bsy[1]));

    dp_ram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .OUT_REG(1), .RDW_MODE(0),
                 .CLEAR_ON_RESET(1), .CLEAR_VALUE(4'h5)) u_c (
        .clk(clk), .reset(rst_c), .wr_en(we[2]), .wr_addr(wa[2][3:0]), .wr_data(wd[2]),
        .rd_en(re[2]), .rd_addr(ra[2][3:0]), .rd_data(rdd[2]), .rd_valid(rdv[2]), .busy(bsy[2]));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void pop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    // Drive one instance for the coming edge and advance the model by that edge.
    task automatic op(input int k, input bit w, input int wa_i, input logic [3:0] d,
                      input bit r, input int ra_i);
        int         msk;
        logic [3:0] old;
        exp_t       e;
        msk   = (k == 2) ? 15 : 1023;
        we[k] = w;
        wa[k] = 10'(wa_i & msk);
        wd[k] = d;
        re[k] = r;
        ra[k] = 10'(ra_i & msk);
        if ((k == 2 && (rst_c || sweep_left > 0)) || (k < 2 && rst_ab)) return;
        old = mdl[k][ra_i & msk];
        if (w) mdl[k][wa_i & msk] = d;
        if (r) begin
            e.d   = (rdw[k] && w && ((wa_i & msk) == (ra_i & msk))) ? d : old;
            e.due = cyc + lat[k];
            push(k, e);
        end
    endtask

    task automatic rand_op(input int k);
        int wa_i;
        int ra_i;
        wa_i = int'($urandom_range(0, 1023));
        ra_i = ($urandom_range(0, 3) == 0) ? wa_i : int'($urandom_range(0, 1023));
        op(k, 1'($urandom), wa_i, 4'($urandom), 1'($urandom), ra_i);
    endtask

    task automatic step();
        if (rst_c) begin
            sweep_left = 16;
            q2.delete();
            last[2] = 4'h0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) for (int i = 0; i < 16; i++) mdl[2][i] = 4'h5;
        end
        exp_busy = rst_c || (sweep_left > 0);
        if (rst_ab) begin
            q0.delete();
            q1.delete();
            last[0] = 4'h0;
            last[1] = 4'h0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0;
            re[k] = 1'b0;
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [3:0] d);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (n > 0) e = (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
        if (v === 1'b1) begin
            vectors++;
            if (n == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid dut%0d cyc=%0d got data=%h, required no result", k, cyc, d);
            end else begin
                pop(k);
                last[k] = e.d;
                if (e.due != cyc || d !== e.d) begin
                    miscompares++;
                    $display("FAIL read_result dut%0d got data=%h at cyc %0d, required %h at cyc %0d",
                             k, d, cyc, e.d, e.due);
                end
            end
        end else begin
            if (n > 0 && e.due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_valid dut%0d cyc=%0d got rd_valid=%b, required 1 data=%h", k, cyc, v, e.d);
                pop(k);
            end
            vectors++;
            if (d !== last[k] || v !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold dut%0d cyc=%0d got data=%h valid=%b, required data=%h valid=0",
                         k, cyc, d, v, last[k]);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) mon(k, rdv[k], rdd[k]);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (bsy[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_tied dut%0d cyc=%0d got %b, required 0", k, cyc, bsy[k]);
            end
        end
        vectors++;
        if (bsy[2] !== exp_busy) begin
            miscompares++;
            $display("FAIL busy_sweep cyc=%0d got %b, required %b (sweep_left=%0d)",
                     cyc, bsy[2], exp_busy, sweep_left);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout cyc=%0d got no end of run, required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        lat = '{1, 2, 2};
        rdw = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            last[k] = 4'h0;
            we[k] = 1'b0; re[k] = 1'b0; wa[k] = '0; ra[k] = '0; wd[k] = '0;
        end
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        step();
        step();
        rst_ab = 1'b0;
        rst_c  = 1'b0;

        // Fill A/B with mem[i]=i[3:0]; meanwhile exercise the sweep on C.
        for (int j = 0; j < 1024; j++) begin
            op(0, 1'b1, j, 4'(j), 1'b0, 0);
            op(1, 1'b1, j, 4'(j), 1'b0, 0);
            rst_c = (j == 60) || (j == 70);
            if (j == 3)                   op(2, 1'b1, 2, 4'hF, 1'b1, 2);
            else if (j == 10)             op(2, 1'b1, 2, 4'hF, 1'b1, 5);
            else if (j >= 20 && j < 36)   op(2, 1'b0, 0, 4'h0, 1'b1, j - 20);
            else if (j >= 40 && j < 56)   op(2, 1'b1, j - 40, 4'($urandom), 1'b0, 0);
            else if (j >= 100 && j < 116) op(2, 1'b0, 0, 4'h0, 1'b1, j - 100);
            else if (j >= 130)            rand_op(2);
            step();
        end
        rst_c = 1'b0;

        // Directed reads, output register, collisions.
        op(0, 1'b0, 0, 4'h0, 1'b1, 'h012); op(1, 1'b1, 5, 4'hA, 1'b0, 0); step();
        op(0, 1'b0, 0, 4'h0, 1'b1, 'h3FE); op(1, 1'b0, 0, 4'h0, 1'b1, 5); step();
        op(0, 1'b0, 0, 4'h0, 1'b1, 'h3FF); op(1, 1'b1, 7, 4'h3, 1'b0, 0); step();
        op(0, 1'b0, 0, 4'h0, 1'b1, 'h000); step();
        op(0, 1'b1, 7, 4'h3, 1'b0, 0);     op(1, 1'b1, 7, 4'hC, 1'b1, 7); step();
        op(0, 1'b1, 7, 4'hC, 1'b1, 7);     step();
        op(0, 1'b0, 0, 4'h0, 1'b1, 7);     op(1, 1'b0, 0, 4'h0, 1'b1, 7); step();
        for (int j = 0; j < 4; j++) step();

        for (int j = 0; j < 2500; j++) begin
            for (int k = 0; k < 3; k++) rand_op(k);
            step();
        end
        for (int j = 0; j < 3; j++) step();

        // Reset with a read in flight, then data written before reset must survive.
        op(0, 1'b0, 0, 4'h0, 1'b1, 5); op(1, 1'b0, 0, 4'h0, 1'b1, 5); step();
        rst_ab = 1'b1; step();
        rst_ab = 1'b0; step();
        op(0, 1'b0, 0, 4'h0, 1'b1, 9); op(1, 1'b0, 0, 4'h0, 1'b1, 7); step();
        op(0, 1'b0, 0, 4'h0, 1'b1, 7); op(1, 1'b0, 0, 4'h0, 1'b1, 'h3FF); step();
        for (int j = 0; j < 4; j++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
